dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/riscv_mem_pkg.sv | 24 ++
 rtl/dmem_word_array.sv | 40 ++++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
//------------------------------------------------------------------------------
// riscv_mem_pkg
//   Shared widths, default sizing and responder FSM state encoding.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package riscv_mem_pkg;

   localparam int WORD_W          = 32;
   localparam int BE_W            = 4;
   localparam int CNT_W           = 4;
   localparam int DEFAULT_DEPTH   = 1024;
   localparam int DEFAULT_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_word_array.sv
//------------------------------------------------------------------------------
// dmem_word_array
//   Word storage with one synchronous byte-enabled write port and one read port.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_word_array
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [BE_W-1:0]   wr_be,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // No reset: contents survive a responder reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// dmem_responder
//   Single-outstanding valid/ready data-memory responder with fixed latency.
//   Optional address bounds checking: define DMEM_BOUNDS_CHECK_EN.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [AW-1:0]     word_idx;
   logic              addr_oob;
   logic              accept;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rdata;
   logic              unused_addr_bits;

   assign word_idx = req_addr[AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
   assign addr_oob = |req_addr[31:AW+2];
`else
   assign addr_oob = 1'b0;
`endif

   assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

   assign accept = (state_q == IDLE) && req_valid;
   assign mem_we = accept && req_we && !addr_oob;

   dmem_word_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (word_idx),
      .wr_data (req_wdata),
      .wr_be   (req_be),
      .rd_addr (word_idx),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = (LATENCY > 1) ? WAIT : RESP;
         WAIT:    if (cnt_q == 4'd1) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The response register is captured at acceptance so later writes cannot alter it.
   always_comb begin
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         cnt_d   = CNT_W'(LATENCY - 1);
         rdata_d = (req_we || addr_oob) ? '0 : mem_rdata;
         err_d   = addr_oob;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q - 4'd1;
      end else if ((state_q == RESP) && rsp_ready) begin
         rdata_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_rdata = rsp_valid ? rdata_q : '0;
      rsp_err   = rsp_valid && err_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// tb_dmem_responder
//   Directed scoreboard bench for dmem_responder (DEPTH=1024, LATENCY=2).
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int vecs  = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model [1024];

   dmem_responder #(
      .DEPTH   (1024),
      .LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_model(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
      exp_t e;
      int   idx;
      logic oob;
      idx = int'(addr[11:2]);
`ifdef DMEM_BOUNDS_CHECK_EN
      oob = |addr[31:12];
`else
      oob = 1'b0;
`endif
      e.err   = oob;
      e.rdata = '0;
      if (!oob) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            e.rdata = model[idx];
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_valid = 1'b1;
   endtask

   // Returns one #1 after the accepting edge with req_valid dropped.
   task automatic issue(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      push_model(we, addr, wdata, be);
      drive(we, addr, wdata, be);
      for (int n = 0; n < 50; n++) begin
         if (req_ready) break;
         @(posedge clk); #1;
      end
      check("req_ready_before_accept", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic collect(input int stall, input string tag);
      exp_t e;
      int   lat;
      rsp_ready = (stall == 0);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         check({tag, "_rdata_while_invalid"}, rsp_rdata, 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(LAT));
      check({tag, "_pending"}, 32'(exp_q.size() > 0), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_stall_rdata"}, rsp_rdata, e.rdata);
         check({tag, "_stall_err"}, 32'(rsp_err), 32'(e.err));
         check({tag, "_stall_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_post_rdata"}, rsp_rdata, 32'd0);
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b1;

      #12;
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      check("reset_req_ready", 32'(req_ready), 32'd1);

      // Basic write then read-back
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      collect(0, "wr10");
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      collect(0, "rd10");

      // Partial byte-enable merge, then an all-disabled write
      issue(1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
      collect(0, "wr20");
      issue(1'b1, 32'h20, 32'h11223344, 4'h5);
      collect(0, "wr20_be5");
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      collect(0, "rd20_merged");
      issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
      collect(0, "wr20_be0");
      issue(1'b0, 32'h20, 32'h0, 4'h0);
      collect(0, "rd20_after_be0");

      // Back-pressure with the next request already waiting on req_valid
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      push_model(1'b0, 32'h20, 32'h0, 4'h0);
      drive(1'b0, 32'h20, 32'h0, 4'h0);
      collect(5, "stall");
      @(posedge clk); #1;
      req_valid = 1'b0;
      collect(0, "held_req");

      // Reset during WAIT of a read discards the response
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      check("rd_wait_req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
         check("post_rst_req_ready", 32'(req_ready), 32'd1);
         @(posedge clk); #1;
      end

      // Reset during WAIT of a write keeps the committed data
      issue(1'b1, 32'h30, 32'hA5A55A5A, 4'hF);
      rst = 1'b0;
      #1;
      check("rst_wr_rsp_valid", 32'(rsp_valid), 32'd0);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      issue(1'b0, 32'h30, 32'h0, 4'h0);
      collect(0, "rd30_after_rst");

      // Out-of-range address: error or aliasing depending on build
      issue(1'b1, 32'h0, 32'h01020304, 4'hF);
      collect(0, "wr0");
      issue(1'b1, 32'h00001000, 32'hCAFEF00D, 4'hF);
      collect(0, "wr_oob");
      issue(1'b0, 32'h0, 32'h0, 4'h0);
      collect(0, "rd0_after_oob");
      issue(1'b0, 32'h20000010, 32'h0, 4'h0);
      collect(0, "rd_oob");

      // A few pseudo-random writes followed by read-back
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 32'h100 + 32'(4*i), $urandom, 4'($urandom_range(1, 15)));
         collect(0, "rnd_wr");
      end
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 32'h100 + 32'(4*i), 32'h0, 4'h0);
         collect(0, "rnd_rd");
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

`default_nettype wire
